// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the two-requester binary-to-BCD converter.
package bcd_conv_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int         BCD_MAX     = 9999;
  localparam int         ITER        = 14;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/bcd_conv_arbiter_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3_step (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbitrated 14-bit binary to 4-digit BCD converter (double dabble).
// Define BCD_SATURATE_EN to saturate out-of-range values to 9999 instead of blanking.
//
// state  | meaning
// IDLE   | sample requests, latch winner's value and index
// CONV   | one double-dabble shift per cycle, 14 cycles
// FIX    | range check, register digits and ovf
// DONE   | one-cycle done pulse to the granted requester
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int W     = 14,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_i,
  input  logic         req1_i,
  input  logic [W-1:0] val0_i,
  input  logic [W-1:0] val1_i,
  output logic         done0_o,
  output logic         done1_o,
  output logic [3:0]   ones_o,
  output logic [3:0]   tens_o,
  output logic [3:0]   hundreds_o,
  output logic [3:0]   thousands_o,
  output logic         ovf_o,
  output logic         busy_o,
  output logic         gnt_o
);

  state_t           state_q, state_d;
  logic [W-1:0]     val_q, val_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      dig_q, dig_d;
  logic             ovf_q, ovf_d;
  logic             gnt_q, gnt_d;
  logic             rr_q, rr_d;   // requester that wins a tie
  logic             pick;

  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3_step u_add3 (
      .d_i(bcd_q[4*g +: 4]),
      .d_o(bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    pick    = (req0_i && req1_i) ? rr_q : req1_i;
    unique case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          gnt_d   = pick;
          rr_d    = ~pick;
          val_d   = pick ? val1_i : val0_i;
          bin_d   = pick ? val1_i : val0_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = (bcd_adj << 1) | {15'd0, bin_q[W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (val_q > W'(BCD_MAX)) begin
          ovf_d = 1'b1;
`ifdef BCD_SATURATE_EN
          dig_d = {4{4'd9}};
`else
          dig_d = {4{BLANK_DIGIT}};
`endif
        end else begin
          ovf_d = 1'b0;
          dig_d = bcd_q;
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done0_o     = (state_q == S_DONE) && !gnt_q;
  assign done1_o     = (state_q == S_DONE) &&  gnt_q;
  assign gnt_o       = gnt_q;
  assign ovf_o       = ovf_q;
  assign thousands_o = dig_q[15:12];
  assign hundreds_o  = dig_q[11:8];
  assign tens_o      = dig_q[7:4];
  assign ones_o      = dig_q[3:0];

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter against a decimal-arithmetic reference model.
module tb_bcd_conv_arbiter;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_i = 1'b0, req1_i = 1'b0;
  logic [W-1:0] val0_i = '0, val1_i = '0;
  logic         done0_o, done1_o, ovf_o, busy_o, gnt_o;
  logic [3:0]   ones_o, tens_o, hundreds_o, thousands_o;

  int n_total = 0;
  int n_bad   = 0;

  bcd_conv_arbiter #(.W(14), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0_i), .req1_i(req1_i),
    .val0_i(val0_i), .val1_i(val1_i),
    .done0_o(done0_o), .done1_o(done1_o),
    .ones_o(ones_o), .tens_o(tens_o), .hundreds_o(hundreds_o), .thousands_o(thousands_o),
    .ovf_o(ovf_o), .busy_o(busy_o), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // {ovf, thousands, hundreds, tens, ones}
  function automatic logic [16:0] model(input int v);
    logic [16:0] r;
    if (v > 9999) begin
`ifdef BCD_SATURATE_EN
      r = {1'b1, 16'h9999};
`else
      r = {1'b1, 16'hFFFF};
`endif
    end else begin
      r = {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    end
    return r;
  endfunction

  function automatic logic [16:0] obs();
    return {ovf_o, thousands_o, hundreds_o, tens_o, ones_o};
  endfunction

  task automatic wait_done(input int limit, output int n, output logic [1:0] dv);
    n  = 0;
    dv = 2'b00;
    while (n < limit && dv == 2'b00) begin
      @(posedge clk); #1;
      n++;
      dv = {done1_o, done0_o};
    end
  endtask

  task automatic do_conv(input int idx, input logic [W-1:0] v);
    logic [16:0] prev;
    logic [1:0]  dv;
    int          n;
    @(negedge clk);
    if (idx == 1) begin req1_i = 1'b1; val1_i = v; end
    else          begin req0_i = 1'b1; val0_i = v; end
    prev = obs();
    @(posedge clk); #1;
    check_eq("grant_idx", 32'(gnt_o), 32'(idx));
    check_eq("busy_conv", 32'(busy_o), 1);
    req0_i = 1'b0; req1_i = 1'b0;
    if (idx == 1) val1_i = ~v; else val0_i = ~v;
    wait_done(14, n, dv);
    check_eq("early_done", 32'(dv), 0);
    check_eq("digits_hold", 32'(obs()), 32'(prev));
    wait_done(1, n, dv);
    check_eq("done_sel", 32'(dv), (idx == 1) ? 2 : 1);
    check_eq("result", 32'(obs()), 32'(model(int'(v))));
    @(posedge clk); #1;
    check_eq("done_one_cycle", 32'({done1_o, done0_o}), 0);
    check_eq("busy_idle", 32'(busy_o), 0);
  endtask

  initial begin
    logic [1:0] dv;
    int         n;

    // reset values
    #1;
    check_eq("rst_outputs", 32'({obs(), done0_o, done1_o, busy_o, gnt_o}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // tie on first post-reset cycle: req0 first, then req1 17 cycles later
    req0_i = 1'b1; val0_i = 14'd500;
    req1_i = 1'b1; val1_i = 14'd42;
    @(posedge clk); #1;
    check_eq("tie_gnt0", 32'(gnt_o), 0);
    wait_done(15, n, dv);
    check_eq("tie_lat0", 32'(n), 15);
    check_eq("tie_done0", 32'(dv), 1);
    check_eq("tie_res0", 32'(obs()), 32'(model(500)));
    @(posedge clk); #1;
    check_eq("tie_idle", 32'(busy_o), 0);
    @(posedge clk); #1;
    check_eq("tie_gnt1", 32'(gnt_o), 1);
    check_eq("tie_busy1", 32'(busy_o), 1);
    req0_i = 1'b0; req1_i = 1'b0;
    wait_done(15, n, dv);
    check_eq("tie_lat1", 32'(n), 15);
    check_eq("tie_done1", 32'(dv), 2);
    check_eq("tie_res1", 32'(obs()), 32'(model(42)));
    @(posedge clk); #1;

    // directed values
    do_conv(0, 14'd1234);
    do_conv(1, 14'd9999);
    do_conv(1, 14'd0);
    do_conv(0, 14'd12000);
    do_conv(0, 14'd10000);
    do_conv(1, 14'd16383);

    // reset during CONV step 7
    @(negedge clk);
    req0_i = 1'b1; val0_i = 14'd1234;
    @(posedge clk); #1;
    req0_i = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_outputs", 32'({obs(), done0_o, done1_o, busy_o, gnt_o}), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(20, n, dv);
    check_eq("midrst_no_done", 32'(dv), 0);
    do_conv(0, 14'd77);

    // continuous request: a conversion every 17 cycles
    @(negedge clk);
    req0_i = 1'b1; val0_i = 14'd305;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("cont_busy", 32'(busy_o), 1);
      wait_done(15, n, dv);
      check_eq("cont_lat", 32'(n), 15);
      check_eq("cont_done", 32'(dv), 1);
      check_eq("cont_res", 32'(obs()), 32'(model(305)));
      if (k == 2) req0_i = 1'b0;
      @(posedge clk); #1;
      check_eq("cont_idle", 32'(busy_o), 0);
    end

    // randomized traffic with range-edge bias
    for (int k = 0; k < 24; k++) begin
      int          idx;
      logic [W-1:0] v;
      idx = int'($urandom_range(0, 1));
      if (k % 4 == 0) v = W'($urandom_range(9990, 10010));
      else            v = W'($urandom_range(0, 16383));
      do_conv(idx, v);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
